// File: rtl/load_store_unit.sv
// Memory stage: LB/LH/LW/LBU/LHU/SB/SH/SW over a req/ack port, pass-through for other ops.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses complete with out_err, no mem_req.
module load_store_unit #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  alu_operation,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_we,
  output logic [4:0]  out_rd,
  output logic [31:0] out_data,
  output logic        out_err
);

  localparam logic [5:0] ALU_OPERATIONS_LB  = 6'h20;
  localparam logic [5:0] ALU_OPERATIONS_LH  = 6'h21;
  localparam logic [5:0] ALU_OPERATIONS_LW  = 6'h22;
  localparam logic [5:0] ALU_OPERATIONS_LBU = 6'h24;
  localparam logic [5:0] ALU_OPERATIONS_LHU = 6'h25;
  localparam logic [5:0] ALU_OPERATIONS_SB  = 6'h28;
  localparam logic [5:0] ALU_OPERATIONS_SH  = 6'h29;
  localparam logic [5:0] ALU_OPERATIONS_SW  = 6'h2A;

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e      r_state;
  logic [5:0]  r_op;
  logic [31:0] r_addr;
  logic [31:0] r_cnt;

  logic        w_is_mem;
  logic        w_is_store;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;
  logic        w_trap;
  logic        w_r_store;
  logic        w_timeout;
  logic [31:0] w_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;

  assign in_ready = (r_state == StIdle);

  always_comb begin
    w_is_mem   = 1'b0;
    w_is_store = 1'b0;
    w_wstrb    = 4'b0000;
    w_wdata    = store_data;
    case (alu_operation)
      ALU_OPERATIONS_LB, ALU_OPERATIONS_LH, ALU_OPERATIONS_LW,
      ALU_OPERATIONS_LBU, ALU_OPERATIONS_LHU: w_is_mem = 1'b1;
      ALU_OPERATIONS_SB: begin
        w_is_mem   = 1'b1;
        w_is_store = 1'b1;
        w_wstrb    = 4'b0001 << alu_result[1:0];
        w_wdata    = {4{store_data[7:0]}};
      end
      ALU_OPERATIONS_SH: begin
        w_is_mem   = 1'b1;
        w_is_store = 1'b1;
        w_wstrb    = 4'b0011 << {alu_result[1], 1'b0};
        w_wdata    = {2{store_data[15:0]}};
      end
      ALU_OPERATIONS_SW: begin
        w_is_mem   = 1'b1;
        w_is_store = 1'b1;
        w_wstrb    = 4'b1111;
      end
      default: ;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    w_trap = 1'b0;
    case (alu_operation)
      ALU_OPERATIONS_LH, ALU_OPERATIONS_LHU, ALU_OPERATIONS_SH: w_trap = alu_result[0];
      ALU_OPERATIONS_LW, ALU_OPERATIONS_SW:                     w_trap = |alu_result[1:0];
      default: ;
    endcase
  end
`else
  assign w_trap = 1'b0;
`endif

  assign w_r_store = (r_op == ALU_OPERATIONS_SB) || (r_op == ALU_OPERATIONS_SH) ||
                     (r_op == ALU_OPERATIONS_SW);
  // Fires on the last permitted ACCESS cycle; mem_ack in that cycle still takes priority.
  assign w_timeout = (ACK_TIMEOUT != 0) && (r_cnt == ACK_TIMEOUT - 1);

  assign w_shift = mem_rdata >> {r_addr[1:0], 3'b000};
  assign w_byte  = w_shift[7:0];
  assign w_half  = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    case (r_op)
      ALU_OPERATIONS_LB:  w_load_data = {{24{w_byte[7]}}, w_byte};
      ALU_OPERATIONS_LBU: w_load_data = {24'h0, w_byte};
      ALU_OPERATIONS_LH:  w_load_data = {{16{w_half[15]}}, w_half};
      ALU_OPERATIONS_LHU: w_load_data = {16'h0, w_half};
      default:            w_load_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= StIdle;
      r_op      <= 6'h0;
      r_addr    <= 32'h0;
      r_cnt     <= 32'h0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wstrb <= 4'h0;
      mem_wdata <= 32'h0;
      out_valid <= 1'b0;
      out_we    <= 1'b0;
      out_rd    <= 5'h0;
      out_data  <= 32'h0;
      out_err   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_op   <= alu_operation;
            r_addr <= alu_result;
            out_rd <= rd_in;
            if (!w_is_mem) begin
              out_data  <= alu_result;
              out_we    <= (rd_in != 5'd0);
              out_err   <= 1'b0;
              out_valid <= 1'b1;
              r_state   <= StDone;
            end else if (w_trap) begin
              out_data  <= alu_result;
              out_we    <= 1'b0;
              out_err   <= 1'b1;
              out_valid <= 1'b1;
              r_state   <= StDone;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= w_is_store;
              mem_addr  <= {alu_result[31:2], 2'b00};
              mem_wstrb <= w_wstrb;
              mem_wdata <= w_wdata;
              r_cnt     <= 32'h0;
              r_state   <= StAccess;
            end
          end
        end
        StAccess: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'h0;
            out_data  <= w_r_store ? 32'h0 : w_load_data;
            out_we    <= !w_r_store && (out_rd != 5'd0);
            out_err   <= 1'b0;
            out_valid <= 1'b1;
            r_state   <= StDone;
          end else if (w_timeout) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'h0;
            out_data  <= r_addr;
            out_we    <= 1'b0;
            out_err   <= 1'b1;
            out_valid <= 1'b1;
            r_state   <= StDone;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: scoreboard of writeback records, memory-side checks.
module tb_load_store_unit;

  localparam logic [5:0] OP_ADD = 6'h00;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h22;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2A;

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
    logic        chk_data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  alu_operation = 6'h0;
  logic [31:0] alu_result = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic [4:0]  rd_in = 5'h0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_we;
  logic [4:0]  out_rd;
  logic [31:0] out_data;
  logic        out_err;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  load_store_unit #(.ACK_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_operation(alu_operation), .alu_result(alu_result), .store_data(store_data),
    .rd_in(rd_in), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_we(out_we), .out_rd(out_rd),
    .out_data(out_data), .out_err(out_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic we, input logic [4:0] rd, input logic [31:0] data,
                      input logic err, input logic chk_data);
    exp_t e;
    e.we = we; e.rd = rd; e.data = data; e.err = err; e.chk_data = chk_data;
    sb_q.push_back(e);
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                       input logic [4:0] rd);
    check("in_ready_before_issue", {31'h0, in_ready}, 32'd1);
    in_valid = 1'b1; alu_operation = op; alu_result = addr; store_data = sdata; rd_in = rd;
    step();
    in_valid = 1'b0;
  endtask

  task automatic mem_respond(input string tag, input int wait_cycles, input logic [31:0] rdata,
                             input logic [31:0] exp_addr, input logic exp_we,
                             input logic [3:0] exp_wstrb, input logic [31:0] exp_wdata,
                             input logic chk_wdata);
    int n = 0;
    while (mem_req !== 1'b1 && n < 20) begin step(); n++; end
    check({tag, "_req"}, {31'h0, mem_req}, 32'd1);
    check({tag, "_addr"}, mem_addr, exp_addr);
    check({tag, "_we"}, {31'h0, mem_we}, {31'h0, exp_we});
    check({tag, "_wstrb"}, {28'h0, mem_wstrb}, {28'h0, exp_wstrb});
    if (chk_wdata) check({tag, "_wdata"}, mem_wdata, exp_wdata);
    for (int i = 0; i < wait_cycles; i++) begin
      step();
      check({tag, "_req_held"}, {31'h0, mem_req}, 32'd1);
      check({tag, "_addr_held"}, mem_addr, exp_addr);
    end
    mem_ack = 1'b1; mem_rdata = rdata;
    step();
    mem_ack = 1'b0; mem_rdata = 32'h0;
  endtask

  task automatic collect(input string tag);
    exp_t e;
    int   n = 0;
    while (out_valid !== 1'b1 && n < 20) begin step(); n++; end
    check({tag, "_out_valid"}, {31'h0, out_valid}, 32'd1);
    if (sb_q.size() == 0) begin
      check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_we"}, {31'h0, out_we}, {31'h0, e.we});
      check({tag, "_rd"}, {27'h0, out_rd}, {27'h0, e.rd});
      check({tag, "_err"}, {31'h0, out_err}, {31'h0, e.err});
      if (e.chk_data) check({tag, "_data"}, out_data, e.data);
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int req_cycles;
    // Reset state
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    check("rst_out_valid", {31'h0, out_valid}, 32'd0);
    check("rst_mem_req", {31'h0, mem_req}, 32'd0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_err", {31'h0, out_err}, 32'd0);
    check("rst_in_ready", {31'h0, in_ready}, 32'd1);

    push(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b1);
    issue(OP_LW, 32'h100, 32'h0, 5'd5);
    mem_respond("lw", 2, 32'hDEADBEEF, 32'h100, 1'b0, 4'b0000, 32'h0, 1'b0);
    collect("lw");

    push(1'b1, 5'd6, 32'hFFFFFF80, 1'b0, 1'b1);
    issue(OP_LB, 32'h103, 32'h0, 5'd6);
    mem_respond("lb", 0, 32'h80FF_0000, 32'h100, 1'b0, 4'b0000, 32'h0, 1'b0);
    collect("lb");

    push(1'b1, 5'd6, 32'h00000080, 1'b0, 1'b1);
    issue(OP_LBU, 32'h103, 32'h0, 5'd6);
    mem_respond("lbu", 1, 32'h80FF_0000, 32'h100, 1'b0, 4'b0000, 32'h0, 1'b0);
    collect("lbu");

    push(1'b1, 5'd7, 32'h000080FF, 1'b0, 1'b1);
    issue(OP_LHU, 32'h102, 32'h0, 5'd7);
    mem_respond("lhu", 0, 32'h80FF_0000, 32'h100, 1'b0, 4'b0000, 32'h0, 1'b0);
    collect("lhu");

    push(1'b1, 5'd8, 32'hFFFF8001, 1'b0, 1'b1);
    issue(OP_LH, 32'h100, 32'h0, 5'd8);
    mem_respond("lh", 0, 32'h1234_8001, 32'h100, 1'b0, 4'b0000, 32'h0, 1'b0);
    collect("lh");

    push(1'b0, 5'd9, 32'h0, 1'b0, 1'b0);
    issue(OP_SB, 32'h201, 32'h12345678, 5'd9);
    mem_respond("sb", 1, 32'h0, 32'h200, 1'b1, 4'b0010, 32'h78787878, 1'b1);
    collect("sb");

    push(1'b0, 5'd9, 32'h0, 1'b0, 1'b0);
    issue(OP_SH, 32'h202, 32'h12345678, 5'd9);
    mem_respond("sh", 0, 32'h0, 32'h200, 1'b1, 4'b1100, 32'h56785678, 1'b1);
    collect("sh");

    push(1'b0, 5'd9, 32'h0, 1'b0, 1'b0);
    issue(OP_SW, 32'h204, 32'h12345678, 5'd9);
    mem_respond("sw", 0, 32'h0, 32'h204, 1'b1, 4'b1111, 32'h12345678, 1'b1);
    collect("sw");

    // Load to x0 still reads memory but must not write back
    push(1'b0, 5'd0, 32'hA5A5A5A5, 1'b0, 1'b1);
    issue(OP_LW, 32'h108, 32'h0, 5'd0);
    mem_respond("lw_x0", 0, 32'hA5A5A5A5, 32'h108, 1'b0, 4'b0000, 32'h0, 1'b0);
    collect("lw_x0");

    // Back-pressure on a pass-through op
    out_ready = 1'b0;
    push(1'b1, 5'd7, 32'h55, 1'b0, 1'b1);
    issue(OP_ADD, 32'h55, 32'h0, 5'd7);
    for (int i = 0; i < 3; i++) begin
      check("hold_out_valid", {31'h0, out_valid}, 32'd1);
      check("hold_out_data", out_data, 32'h55);
      check("hold_in_ready", {31'h0, in_ready}, 32'd0);
      check("hold_mem_req", {31'h0, mem_req}, 32'd0);
      step();
    end
    out_ready = 1'b1;
    collect("add");

    // Timeout: no ack ever
    push(1'b0, 5'd8, 32'h300, 1'b1, 1'b1);
    issue(OP_LW, 32'h300, 32'h0, 5'd8);
    req_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid === 1'b1) break;
      if (mem_req === 1'b1) req_cycles++;
      step();
    end
    check("timeout_req_cycles", req_cycles, 32'd4);
    check("timeout_req_dropped", {31'h0, mem_req}, 32'd0);
    collect("timeout");

    // Ack on the limit cycle completes normally
    push(1'b1, 5'd9, 32'hCAFEF00D, 1'b0, 1'b1);
    issue(OP_LW, 32'h400, 32'h0, 5'd9);
    mem_respond("ack_at_limit", 3, 32'hCAFEF00D, 32'h400, 1'b0, 4'b0000, 32'h0, 1'b0);
    collect("ack_at_limit");

    // Reset mid-ACCESS discards the op; a stray ack afterwards is ignored
    issue(OP_LW, 32'h500, 32'h0, 5'd10);
    check("midrst_req_before", {31'h0, mem_req}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_req_after", {31'h0, mem_req}, 32'd0);
    check("midrst_out_valid", {31'h0, out_valid}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h12121212;
    step();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    step();
    check("stray_ack_out_valid", {31'h0, out_valid}, 32'd0);
    check("stray_ack_mem_req", {31'h0, mem_req}, 32'd0);
    push(1'b1, 5'd11, 32'h0BADF00D, 1'b0, 1'b1);
    issue(OP_LW, 32'h100, 32'h0, 5'd11);
    mem_respond("post_rst_lw", 0, 32'h0BADF00D, 32'h100, 1'b0, 4'b0000, 32'h0, 1'b0);
    collect("post_rst_lw");

`ifdef MISALIGN_TRAP_EN
    push(1'b0, 5'd12, 32'h102, 1'b1, 1'b1);
    issue(OP_LW, 32'h102, 32'h0, 5'd12);
    check("misalign_no_req", {31'h0, mem_req}, 32'd0);
    collect("misalign_lw");
`else
    push(1'b1, 5'd12, 32'h11223344, 1'b0, 1'b1);
    issue(OP_LW, 32'h102, 32'h0, 5'd12);
    mem_respond("misalign_lw", 0, 32'h11223344, 32'h100, 1'b0, 4'b0000, 32'h0, 1'b0);
    collect("misalign_lw");
`endif

    check("sb_drained", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
